cordic_gain_comp: RTL and testbench

- Downstream neighbour of the 8-stage pipelined CORDIC rotator; sits directly on the rotator's xf/yf outputs.
- Removes the CORDIC gain (K ≈ 1.6468) by multiplying both outputs by 1/K ≈ 0.6074 with shift-add logic.
- The rotator has no valid or stall, so this block tracks sample validity through the rotator latency.
- Buffers results in a small FIFO and throttles the upstream source with credit-based in_ready so no sample is lost under downstream back-pressure.

---
 rtl/cordic_pkg.sv | 31 +++
 rtl/cordic_gain_comp_if.sv | 32 +++
 rtl/cordic_gain_fifo.sv | 59 +++++
 rtl/cordic_gain_comp.sv | 87 ++++++++
 tb/tb_cordic_gain_comp.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Purpose  : Shared constants and the 1/K gain-compensation helper for the
//            CORDIC rotator family.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int c_W_DEFAULT       = 16;
    localparam int c_LATENCY_DEFAULT = 8;

    // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 (~0.6074); the last two terms subtract
    localparam int c_GAIN_SH0 = 1;
    localparam int c_GAIN_SH1 = 3;
    localparam int c_GAIN_SH2 = 6;
    localparam int c_GAIN_SH3 = 9;

    // Angles are carried in hundredths of a degree
    localparam int c_ANGLE_UNIT = 100;

    // Operates on a sign-extended 32-bit value so any W up to 32 can share it.
    // Each arithmetic shift floors toward -inf. The magnitude of the result is
    // always below that of the input, so truncating back to W bits is lossless.
    function automatic logic signed [31:0] gain_comp(input logic signed [31:0] x);
        return (x >>> c_GAIN_SH0) + (x >>> c_GAIN_SH1)
             - (x >>> c_GAIN_SH2) - (x >>> c_GAIN_SH3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_gain_comp_if.sv
`default_nettype none
// ============================================================================
// Module   : cordic_gain_comp_if
// Purpose  : Source/sink handshake and data bundle of the gain compensator.
// Revision : 1.0 - initial release
// ============================================================================
interface cordic_gain_comp_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] xr;
    logic [W-1:0] yr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] xo;
    logic [W-1:0] yo;
    logic         drop_err;

    // Environment side: upstream source plus downstream consumer
    modport master (
        output in_valid, xr, yr, out_ready,
        input  in_ready, out_valid, xo, yo, drop_err
    );

    // Compensator side
    modport slave (
        input  in_valid, xr, yr, out_ready,
        output in_ready, out_valid, xo, yo, drop_err
    );
endinterface
`default_nettype wire

// File: rtl/cordic_gain_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cordic_gain_fifo
// Purpose  : Show-ahead FIFO with occupancy count for compensated samples.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_gain_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_push,
    input  wire logic [DW-1:0] i_push_data,
    input  wire logic          i_pop,
    output logic      [DW-1:0] o_head_data,
    output logic      [CW-1:0] o_count
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Guard against underflow, and allow a push into a full FIFO only when a
    // pop frees a slot in the same cycle
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is data-only; validity is governed entirely by the count
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/cordic_gain_comp.sv
`default_nettype none
// ============================================================================
// Module   : cordic_gain_comp
// Purpose  : Removes the CORDIC gain from the rotator outputs, tracks sample
//            validity through the rotator latency and throttles the source
//            with credits so buffered results are never lost.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int W       = c_W_DEFAULT,
    parameter int LATENCY = c_LATENCY_DEFAULT,
    parameter int DEPTH   = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    cordic_gain_comp_if.slave bus
);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] r_tag;
    logic               r_drop_err;
    logic               w_accept;
    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_out_valid;
    logic [FW-1:0]      w_count;
    logic [CW-1:0]      w_inflight;
    logic [W-1:0]       w_xs;
    logic [W-1:0]       w_ys;
    logic [2*W-1:0]     w_head;

    // Every sample in the tag line already owns a FIFO slot (its credit)
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_tag[i]);
        end
    end

    assign w_in_ready = (CW'(w_count) + w_inflight) < CW'(DEPTH);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Validity marker travels alongside the rotator pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) r_tag <= '0;
        else        r_tag <= {r_tag[LATENCY-2:0], w_accept};
    end

    // A sample offered without credit is discarded and flagged until reset
    always_ff @(posedge clk) begin
        if (!rst_n)                             r_drop_err <= 1'b0;
        else if (bus.in_valid && !w_in_ready)   r_drop_err <= 1'b1;
    end

    assign w_xs = W'(gain_comp(32'(signed'(bus.xr))));
    assign w_ys = W'(gain_comp(32'(signed'(bus.yr))));

    // The credit check guarantees a free slot whenever the tag line exits
    assign w_push      = r_tag[LATENCY-1];
    assign w_out_valid = (w_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;

    cordic_gain_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({w_xs, w_ys}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_count)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.xo        = w_out_valid ? w_head[2*W-1:W] : '0;
    assign bus.yo        = w_out_valid ? w_head[W-1:0]   : '0;
    assign bus.drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_cordic_gain_comp.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_gain_comp
// Purpose  : Directed self-checking bench; an identity rotator model (a plain
//            LATENCY-stage delay line) feeds xr/yr to two compensator
//            instances with DEPTH=4 and DEPTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_gain_comp;
    localparam int W = 16;
    localparam int L = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_gain_comp_if #(.W(W)) if4 ();
    cordic_gain_comp_if #(.W(W)) if16 ();

    cordic_gain_comp #(.W(W), .LATENCY(L), .DEPTH(4)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .bus (if4)
    );
    cordic_gain_comp #(.W(W), .LATENCY(L), .DEPTH(16)) u_dut16 (
        .clk (clk), .rst_n (rst_n), .bus (if16)
    );

    // Rotator stand-in: x0/y0 presented with in_valid emerge L edges later
    logic signed [W-1:0] x0, y0;
    logic [W-1:0] r_px [L];
    logic [W-1:0] r_py [L];
    always @(posedge clk) begin
        r_px[0] <= x0;
        r_py[0] <= y0;
        for (int i = 1; i < L; i++) begin
            r_px[i] <= r_px[i-1];
            r_py[i] <= r_py[i-1];
        end
    end
    assign if4.xr  = r_px[L-1];
    assign if4.yr  = r_py[L-1];
    assign if16.xr = r_px[L-1];
    assign if16.yr = r_py[L-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if4.in_valid = 0; if4.out_ready = 0;
        if16.in_valid = 0; if16.out_ready = 0;
        x0 = '0; y0 = '0;
        rst_n = 0;
        step();
        rst_n = 1;
        n_cmp++; if (if4.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", if4.out_valid); end
        n_cmp++; if (if4.xo !== 16'd0) begin n_bad++; $display("FAIL rst_xo: got %0d want 0", $signed(if4.xo)); end
        n_cmp++; if (if4.yo !== 16'd0) begin n_bad++; $display("FAIL rst_yo: got %0d want 0", $signed(if4.yo)); end
        n_cmp++; if (if4.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %0b want 1", if4.in_ready); end
        n_cmp++; if (if4.drop_err !== 1'b0) begin n_bad++; $display("FAIL rst_drop_err: got %0b want 0", if4.drop_err); end
    endtask

    task automatic test_positive_scale();
        int lat;
        x0 = 16'sd10000; y0 = 16'sd0;
        if4.in_valid = 1;
        step();
        if4.in_valid = 0;
        lat = 1;
        while (!if4.out_valid && lat < 30) begin
            step();
            lat++;
        end
        n_cmp++; if (lat !== L + 1) begin n_bad++; $display("FAIL pos_latency: got %0d edges want %0d", lat, L + 1); end
        n_cmp++; if (if4.xo !== 16'sd6075) begin n_bad++; $display("FAIL pos_xo: got %0d want 6075", $signed(if4.xo)); end
        n_cmp++; if (if4.yo !== 16'sd0) begin n_bad++; $display("FAIL pos_yo: got %0d want 0", $signed(if4.yo)); end
        if4.out_ready = 1;
        step();
        if4.out_ready = 0;
        n_cmp++; if (if4.out_valid !== 1'b0) begin n_bad++; $display("FAIL pos_drained: got %0b want 0", if4.out_valid); end
    endtask

    task automatic test_negative_scale();
        int k;
        logic signed [W-1:0] ex;
        x0 = -16'sd10000; y0 = -16'sd32768;
        if4.in_valid = 1;
        step();
        x0 = 16'sd32767; y0 = -16'sd1;
        step();
        if4.in_valid = 0;
        if4.out_ready = 1;
        k = 0;
        while (!if4.out_valid && k < 30) begin
            step();
            k++;
        end
        n_cmp++; if (if4.out_valid !== 1'b1) begin n_bad++; $display("FAIL neg_timeout: out_valid %0b want 1", if4.out_valid); end
        ex = -16'sd6073;
        n_cmp++; if (if4.xo !== ex) begin n_bad++; $display("FAIL neg_xo: got %0d want -6073", $signed(if4.xo)); end
        ex = -16'sd19904;
        n_cmp++; if (if4.yo !== ex) begin n_bad++; $display("FAIL neg_yo: got %0d want -19904", $signed(if4.yo)); end
        step();
        n_cmp++; if (if4.out_valid !== 1'b1) begin n_bad++; $display("FAIL max_valid: got %0b want 1", if4.out_valid); end
        n_cmp++; if (if4.xo !== 16'sd19904) begin n_bad++; $display("FAIL max_xo: got %0d want 19904", $signed(if4.xo)); end
        n_cmp++; if (if4.yo !== 16'sd0) begin n_bad++; $display("FAIL minus1_yo: got %0d want 0", $signed(if4.yo)); end
        step();
        if4.out_ready = 0;
        n_cmp++; if (if4.out_valid !== 1'b0) begin n_bad++; $display("FAIL neg_drained: got %0b want 0", if4.out_valid); end
    endtask

    task automatic test_back_pressure();
        logic signed [W-1:0] ex [4];
        logic signed [W-1:0] ey [4];
        int acc;
        int nout;
        ex[0] = 16'sd609;  ex[1] = 16'sd1216;  ex[2] = 16'sd1824;  ex[3] = 16'sd2431;
        ey[0] = -16'sd607; ey[1] = -16'sd1214; ey[2] = -16'sd1822; ey[3] = -16'sd2429;
        if4.out_ready = 0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin
                n_cmp++; if (if4.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_5th: got %0b want 0", if4.in_ready); end
            end
            if (if4.in_ready) begin
                if4.in_valid = 1;
                x0 = W'(1000 * (acc + 1));
                y0 = -x0;
                acc++;
            end else begin
                if4.in_valid = 0;
            end
            step();
        end
        if4.in_valid = 0;
        n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL bp_accepted: got %0d want 4", acc); end
        for (int k = 0; k < L + 2; k++) step();
        n_cmp++; if (if4.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_full_valid: got %0b want 1", if4.out_valid); end
        n_cmp++; if (if4.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %0b want 0", if4.in_ready); end
        if4.out_ready = 1;
        nout = 0;
        for (int k = 0; k < 12 && nout < 4; k++) begin
            if (if4.out_valid) begin
                n_cmp++; if (if4.xo !== ex[nout]) begin n_bad++; $display("FAIL bp_xo[%0d]: got %0d want %0d", nout, $signed(if4.xo), ex[nout]); end
                n_cmp++; if (if4.yo !== ey[nout]) begin n_bad++; $display("FAIL bp_yo[%0d]: got %0d want %0d", nout, $signed(if4.yo), ey[nout]); end
                nout++;
            end
            step();
            if (nout == 1 && k == 0) begin
                n_cmp++; if (if4.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_return: got %0b want 1", if4.in_ready); end
            end
        end
        if4.out_ready = 0;
        n_cmp++; if (nout !== 4) begin n_bad++; $display("FAIL bp_outputs: got %0d want 4", nout); end
        n_cmp++; if (if4.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %0b want 0", if4.out_valid); end
        n_cmp++; if (if4.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_end: got %0b want 1", if4.in_ready); end
    endtask

    task automatic test_streaming();
        int nout;
        int first;
        int last;
        int ready_low;
        logic signed [W-1:0] ex;
        nout = 0; first = -1; last = -1; ready_low = 0;
        if16.out_ready = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (if16.out_valid) begin
                ex = W'(311 * (nout + 1));
                n_cmp++; if (if16.xo !== ex) begin n_bad++; $display("FAIL str_xo[%0d]: got %0d want %0d", nout, $signed(if16.xo), ex); end
                ex = -ex;
                n_cmp++; if (if16.yo !== ex) begin n_bad++; $display("FAIL str_yo[%0d]: got %0d want %0d", nout, $signed(if16.yo), ex); end
                if (nout == 0) first = cyc;
                last = cyc;
                nout++;
            end
            if (cyc < 20) begin
                if (!if16.in_ready) ready_low++;
                if16.in_valid = 1;
                x0 = W'(512 * (cyc + 1));
                y0 = -x0;
            end else begin
                if16.in_valid = 0;
            end
            step();
        end
        if16.in_valid = 0;
        if16.out_ready = 0;
        n_cmp++; if (nout !== 20) begin n_bad++; $display("FAIL str_count: got %0d want 20", nout); end
        n_cmp++; if (last - first !== 19) begin n_bad++; $display("FAIL str_consecutive: span %0d want 19", last - first); end
        n_cmp++; if (ready_low !== 0) begin n_bad++; $display("FAIL str_ready: low %0d cycles want 0", ready_low); end
    endtask

    task automatic test_protocol();
        int nout;
        if4.out_ready = 0;
        for (int c = 0; c < 6; c++) begin
            if (if4.in_ready) begin
                if4.in_valid = 1;
                x0 = W'(512 * (c + 1));
                y0 = x0;
            end else begin
                if4.in_valid = 0;
            end
            step();
        end
        if4.in_valid = 0;
        n_cmp++; if (if4.in_ready !== 1'b0) begin n_bad++; $display("FAIL prot_pre_ready: got %0b want 0", if4.in_ready); end
        n_cmp++; if (if4.drop_err !== 1'b0) begin n_bad++; $display("FAIL prot_pre_err: got %0b want 0", if4.drop_err); end
        if4.in_valid = 1;
        x0 = 16'sd7777; y0 = 16'sd7777;
        step();
        if4.in_valid = 0;
        n_cmp++; if (if4.drop_err !== 1'b1) begin n_bad++; $display("FAIL prot_err_set: got %0b want 1", if4.drop_err); end
        for (int k = 0; k < L + 2; k++) step();
        n_cmp++; if (if4.drop_err !== 1'b1) begin n_bad++; $display("FAIL prot_err_sticky: got %0b want 1", if4.drop_err); end
        if4.out_ready = 1;
        nout = 0;
        for (int k = 0; k < 15; k++) begin
            if (if4.out_valid) nout++;
            step();
        end
        if4.out_ready = 0;
        n_cmp++; if (nout !== 4) begin n_bad++; $display("FAIL prot_outputs: got %0d want 4", nout); end
        n_cmp++; if (if4.drop_err !== 1'b1) begin n_bad++; $display("FAIL prot_err_end: got %0b want 1", if4.drop_err); end
    endtask

    task automatic test_reset_midflight();
        int seen;
        if16.out_ready = 0;
        if16.in_valid = 1;
        x0 = 16'sd512;  y0 = 16'sd512;
        step();
        x0 = 16'sd1024; y0 = 16'sd1024;
        step();
        if16.in_valid = 0;
        for (int k = 0; k < L; k++) step();
        if16.in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            x0 = W'(1536 + 512 * k);
            y0 = x0;
            step();
        end
        if16.in_valid = 0;
        n_cmp++; if (if16.out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %0b want 1", if16.out_valid); end
        rst_n = 0;
        step();
        rst_n = 1;
        n_cmp++; if (if16.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %0b want 0", if16.out_valid); end
        n_cmp++; if (if16.xo !== 16'd0) begin n_bad++; $display("FAIL mid_xo: got %0d want 0", $signed(if16.xo)); end
        n_cmp++; if (if16.yo !== 16'd0) begin n_bad++; $display("FAIL mid_yo: got %0d want 0", $signed(if16.yo)); end
        n_cmp++; if (if16.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %0b want 1", if16.in_ready); end
        n_cmp++; if (if16.drop_err !== 1'b0) begin n_bad++; $display("FAIL mid_drop_err: got %0b want 0", if16.drop_err); end
        n_cmp++; if (if4.drop_err !== 1'b0) begin n_bad++; $display("FAIL mid_drop_err4: got %0b want 0", if4.drop_err); end
        if16.out_ready = 1;
        seen = 0;
        for (int k = 0; k < 2 * L + 4; k++) begin
            step();
            if (if16.out_valid) seen++;
        end
        if16.out_ready = 0;
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_stale: %0d stale outputs want 0", seen); end
    endtask

    initial begin
        rst_n = 1;
        test_reset();
        test_positive_scale();
        test_negative_scale();
        test_back_pressure();
        test_streaming();
        test_protocol();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
